// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding selects, load-use and branch
// handling, and a RUN/MEM_WAIT FSM that freezes the pipeline during slow data-memory accesses.
// Optional macro PIPE_PERF_CNT_EN adds StallCycles/FlushCount performance counters.
module pipeline_ctrl #(
  parameter int REG_W       = 6,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]      StallCycles,
  output logic [31:0]      FlushCount
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_nxt;
  logic             hold;
  logic             lw_stall;
  logic [1:0]       fwd_a, fwd_b;

  always_comb begin
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    hold      = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = MemErr;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;

    // The M stage holds the younger result, so it takes priority over W.
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      fwd_a = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) fwd_a = 2'b01;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      fwd_b = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) fwd_b = 2'b01;

    lw_stall = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    unique case (state)
      RUN: begin
        if (MemReqM && !MemAckM) begin
          hold      = 1'b1;
          state_nxt = MEM_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemAckM) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          hold = 1'b1;
          if (cnt == CNT_LAST) begin
            err_nxt   = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = RUN;
    endcase

    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (hold) begin
        // Whole pipe frozen; branch and load-use re-evaluate once the access completes.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall && !PCSrcE;
        StallD = lw_stall && !PCSrcE;
        FlushE = lw_stall || PCSrcE;
        FlushD = PCSrcE;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= '0;
      MemErr <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      MemErr <= err_nxt;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF)           StallCycles <= StallCycles + 32'd1;
      if (FlushD || FlushE) FlushCount  <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_ctrl;
  localparam int REG_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [REG_W-1:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic             RegWriteM = 1'b0, RegWriteW = 1'b0, PCSrcE = 1'b0, MemReqM = 1'b0, MemAckM = 1'b0;
  logic [1:0]       ResultSrcE = 2'b00;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0]       ForwardAE, ForwardBE;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]      StallCycles, FlushCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [11:0] v;
    string       name;
  } exp_t;
  exp_t q[$];

  pipeline_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr)
`ifdef PIPE_PERF_CNT_EN
    , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
  );

  always #5 clk = ~clk;

  // {stalls F/D/E/M, flushes D/E/W, ForwardAE, ForwardBE, MemErr}
  function automatic logic [11:0] mk(logic [3:0] st, logic [2:0] fl, logic [1:0] fa,
                                     logic [1:0] fb, logic err);
    return {st, fl, fa, fb, err};
  endfunction

  task automatic cyc(input string name, input logic [11:0] e);
    exp_t x;
    x.v    = e;
    x.name = name;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemAckM = 1'b0;
  endtask

  // Monitor: outputs are presented every cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [11:0] act;
      x   = q.pop_front();
      act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, MemErr};
      n_checks++;
      if (act !== x.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (SFDEM FDEW FA FB ERR)", x.name, act, x.v);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    clr();
    rst = 1'b1;
    cyc("rst0", mk(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0));
    cyc("rst1", mk(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0));
    rst = 1'b0;
    cyc("idle", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));

    // Forwarding
    Rs1E = 6'd5; RdM = 6'd5; RegWriteM = 1'b1; Rs2E = 6'd7; RdW = 6'd7; RegWriteW = 1'b1;
    cyc("fwd_m_w", mk(4'b0000, 3'b000, 2'b10, 2'b01, 1'b0));
    RdW = 6'd5; Rs2E = 6'd5;
    cyc("fwd_double", mk(4'b0000, 3'b000, 2'b10, 2'b10, 1'b0));
    RegWriteM = 1'b0;
    cyc("fwd_nowm", mk(4'b0000, 3'b000, 2'b01, 2'b01, 1'b0));
    RegWriteM = 1'b1; RdM = 6'd0; RdW = 6'd0; Rs1E = 6'd0; Rs2E = 6'd0;
    cyc("fwd_r0", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
    clr();

    // Load-use and branch
    ResultSrcE = 2'b01; RdE = 6'd3; Rs2D = 6'd3;
    cyc("lw_stall", mk(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0));
    PCSrcE = 1'b1;
    cyc("lw_branch", mk(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0));
    PCSrcE = 1'b0; RdE = 6'd0; Rs2D = 6'd0;
    cyc("lw_r0", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
    ResultSrcE = 2'b00; RdE = 6'd4; Rs1D = 6'd4;
    cyc("alu_nostall", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
    clr();

    // 3-cycle memory access
    MemReqM = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc($sformatf("mem_wait%0d", i), mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0));
    MemAckM = 1'b1;
    cyc("mem_ack", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
    clr();
    cyc("mem_after", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
    MemReqM = 1'b1; MemAckM = 1'b1;
    cyc("mem_zero_wait", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
    clr();
`ifdef PIPE_PERF_CNT_EN
    n_checks++;
    if (StallCycles !== 32'd4 || FlushCount !== 32'd2) begin
      n_fail++;
      $display("FAIL perf: got stall=%0d flush=%0d expected stall=4 flush=2", StallCycles, FlushCount);
    end
`endif

    // Timeout with a branch pending: the branch is deferred throughout the stall
    MemReqM = 1'b1; PCSrcE = 1'b1;
    for (int i = 0; i < 16; i++)
      cyc($sformatf("tmo_stall%0d", i), mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0));
    MemReqM = 1'b0; PCSrcE = 1'b0;
    cyc("tmo_err", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b1));
    cyc("tmo_sticky", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b1));
    rst = 1'b1;
    cyc("tmo_rst", mk(4'b0000, 3'b111, 2'b00, 2'b00, 1'b1));
    rst = 1'b0;
    cyc("tmo_cleared", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));

    // Reset in the middle of MEM_WAIT
    MemReqM = 1'b1;
    cyc("mid_req", mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0));
    cyc("mid_wait", mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0));
    rst = 1'b1;
    cyc("mid_rst", mk(4'b0000, 3'b111, 2'b00, 2'b00, 1'b0));
    rst = 1'b0; MemReqM = 1'b0;
    cyc("mid_run", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
`ifdef PIPE_PERF_CNT_EN
    n_checks++;
    if (StallCycles !== 32'd0 || FlushCount !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_rst: got stall=%0d flush=%0d expected 0 and 0", StallCycles, FlushCount);
    end
`endif

    @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
